matmul_sequencer: RTL and testbench

- Counter-driven sequencer for the matrix-multiply datapath. It computes C = A x B, where A is ROWS x INNER and B is INNER x COLS, both row-major in operand memories.
- For each result element it issues operand read addresses and drives the clear/enable pair of the shared MAC. It presents the finished element to the output stage with a valid/ready handshake.
- It replaces hard-coded per-state select tables with index counters, so matrix sizes are parameter changes only.

---
 rtl/matmul_sequencer.sv | 161 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Counter-driven address/strobe sequencer for a shared-MAC matrix multiply C = A x B.
// A and B are row-major; one result element is produced per INNER+2 cycles when unstalled.
module matmul_sequencer #(
    parameter int ROWS  = 3,
    parameter int INNER = 4,
    parameter int COLS  = 3,
    parameter int AW    = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          rd_en,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [IW-1:0] res_row,
    output logic [IW-1:0] res_col,
    output logic          res_last,
    output logic          busy,
    output logic          done
);

    localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic [KW-1:0] k_q;
    logic [AW-1:0] a_base_q;
    logic [AW-1:0] a_addr_q;
    logic [AW-1:0] b_addr_q;
    logic          rd_en_q;
    logic          mac_en_q;
    logic          mac_clr_q;
    logic          res_valid_q;
    logic [IW-1:0] res_row_q;
    logic [IW-1:0] res_col_q;
    logic          res_last_q;
    logic          busy_q;
    logic          done_q;

    // Handshake: res_valid rises on OUT entry and the element is transferred in the
    // cycle where res_valid && res_ready; everything on the result side holds until then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_base_q    <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            rd_en_q     <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Operand data arrives one cycle after the read, so the MAC strobes trail rd_en.
            mac_en_q  <= rd_en_q;
            mac_clr_q <= rd_en_q && (k_q == '0);
            done_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_ACCUM;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        a_base_q <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                        rd_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (k_q == KW'(INNER - 1)) begin
                        state_q <= S_FLUSH;
                        rd_en_q <= 1'b0;
                    end else begin
                        k_q      <= k_q + KW'(1);
                        a_addr_q <= a_addr_q + AW'(1);
                        b_addr_q <= b_addr_q + AW'(COLS);
                        rd_en_q  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    state_q     <= S_OUT;
                    res_valid_q <= 1'b1;
                    res_row_q   <= i_q;
                    res_col_q   <= j_q;
                    res_last_q  <= (i_q == IW'(ROWS - 1)) && (j_q == IW'(COLS - 1));
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_last_q  <= 1'b0;
                        if (res_last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ACCUM;
                            k_q     <= '0;
                            rd_en_q <= 1'b1;
                            // Row wrap moves the A base by one row; B restarts at column 0.
                            if (j_q == IW'(COLS - 1)) begin
                                j_q      <= '0;
                                i_q      <= i_q + IW'(1);
                                a_base_q <= a_base_q + AW'(INNER);
                                a_addr_q <= a_base_q + AW'(INNER);
                                b_addr_q <= '0;
                            end else begin
                                j_q      <= j_q + IW'(1);
                                a_addr_q <= a_base_q;
                                b_addr_q <= AW'(j_q + IW'(1));
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_addr    = a_addr_q;
    assign b_addr    = b_addr_q;
    assign rd_en     = rd_en_q;
    assign mac_en    = mac_en_q;
    assign mac_clr   = mac_clr_q;
    assign res_valid = res_valid_q;
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;
    assign res_last  = res_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: cycle tables for a 3x4x3 and a 2x1x2 instance, a memory/MAC
// model feeding a result scoreboard, and directed stall, re-start and mid-run reset sequences.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic       reset, start, res_ready;
  logic [3:0] a_addr, b_addr;
  logic       rd_en, mac_en, mac_clr, res_valid, res_last, busy, done;
  logic [1:0] res_row, res_col;

  // ROWS=2, INNER=1, COLS=2 instance
  logic       reset2, start2, res_ready2;
  logic [3:0] a_addr2, b_addr2;
  logic       rd_en2, mac_en2, mac_clr2, res_valid2, res_last2, busy2, done2;
  logic [1:0] res_row2, res_col2;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
    .mac_en(mac_en), .mac_clr(mac_clr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_col(res_col), .res_last(res_last),
    .busy(busy), .done(done)
  );

  matmul_sequencer #(.ROWS(2), .INNER(1), .COLS(2), .AW(4), .IW(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .a_addr(a_addr2), .b_addr(b_addr2), .rd_en(rd_en2),
    .mac_en(mac_en2), .mac_clr(mac_clr2),
    .res_valid(res_valid2), .res_ready(res_ready2),
    .res_row(res_row2), .res_col(res_col2), .res_last(res_last2),
    .busy(busy2), .done(done2)
  );

  // Operand memories A[n]=n+1, B[n]=n+1 with one-cycle read latency, and the shared MAC.
  int a_dat, b_dat, acc;
  always @(posedge clk) begin
    if (rd_en) begin
      a_dat <= int'(a_addr) + 1;
      b_dat <= int'(b_addr) + 1;
    end
    if (mac_en) acc <= mac_clr ? a_dat * b_dat : acc + a_dat * b_dat;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          which;
    int          cyc;
    logic [18:0] exp;
  } vec_t;
  vec_t vecs[$];

  logic [18:0] log1 [0:63];
  logic [18:0] log2 [0:63];

  function automatic logic [18:0] mk(input int a, b, rd, me, mc, rv, row, col, last, bz, dn);
    return {4'(a), 4'(b), 1'(rd), 1'(me), 1'(mc), 1'(rv), 2'(row), 2'(col), 1'(last), 1'(bz), 1'(dn)};
  endfunction

  function automatic logic [18:0] obs1();
    return {a_addr, b_addr, rd_en, mac_en, mac_clr, res_valid, res_row, res_col, res_last, busy, done};
  endfunction

  function automatic logic [18:0] obs2();
    return {a_addr2, b_addr2, rd_en2, mac_en2, mac_clr2, res_valid2, res_row2, res_col2, res_last2, busy2, done2};
  endfunction

  function automatic int c_ref(input int i, input int j);
    int s = 0;
    for (int k = 0; k < 4; k++) s += (i * 4 + k + 1) * (k * 3 + j + 1);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        exp_q.push_back({8'(i), 8'(j), 16'(c_ref(i, j))});
  endtask

  task automatic sb_sample();
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_elem", {8'(res_row), 8'(res_col), 16'(acc)}, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    int n_mac, n_clr, n_valid, n_last, n_done, done_cyc, clr_mis2, budget;
    logic [1:0] hold_row, hold_col;
    logic stall_ok;

    vecs = '{
      '{1, 0,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)},
      '{1, 1,  mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)},
      '{1, 2,  mk(1, 3, 1, 1, 1, 0, 0, 0, 0, 1, 0)},
      '{1, 3,  mk(2, 6, 1, 1, 0, 0, 0, 0, 0, 1, 0)},
      '{1, 4,  mk(3, 9, 1, 1, 0, 0, 0, 0, 0, 1, 0)},
      '{1, 5,  mk(3, 9, 0, 1, 0, 0, 0, 0, 0, 1, 0)},
      '{1, 6,  mk(3, 9, 0, 0, 0, 1, 0, 0, 0, 1, 0)},
      '{1, 7,  mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0)},
      '{1, 31, mk(4, 2, 1, 0, 0, 0, 1, 1, 0, 1, 0)},
      '{1, 32, mk(5, 5, 1, 1, 1, 0, 1, 1, 0, 1, 0)},
      '{1, 34, mk(7, 11, 1, 1, 0, 0, 1, 1, 0, 1, 0)},
      '{1, 54, mk(11, 11, 0, 0, 0, 1, 2, 2, 1, 1, 0)},
      '{1, 55, mk(11, 11, 0, 0, 0, 0, 2, 2, 0, 1, 1)},
      '{1, 56, mk(11, 11, 0, 0, 0, 0, 2, 2, 0, 0, 0)},
      '{2, 0,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)},
      '{2, 1,  mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)},
      '{2, 2,  mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)},
      '{2, 3,  mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0)},
      '{2, 4,  mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0)},
      '{2, 6,  mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0)},
      '{2, 7,  mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0)},
      '{2, 9,  mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0)},
      '{2, 12, mk(1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0)},
      '{2, 13, mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1)},
      '{2, 14, mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0)}
    };

    // Clock/reset
    reset = 1'b1; start = 1'b0; res_ready = 1'b1;
    reset2 = 1'b1; start2 = 1'b0; res_ready2 = 1'b1;
    repeat (3) tick();
    reset = 1'b0; reset2 = 1'b0;
    tick();

    // Run 1: both instances from a start pulse at cycle 0, res_ready tied high
    check("c_ref_1_2", 32'(c_ref(1, 2)), 32'd210);
    push_all();
    n_mac = 0; n_clr = 0; n_valid = 0; n_last = 0; n_done = 0; done_cyc = -1; clr_mis2 = 0;
    log1[0] = obs1();
    log2[0] = obs2();
    start = 1'b1; start2 = 1'b1;
    for (int c = 1; c < 64; c++) begin
      tick();
      start = 1'b0; start2 = 1'b0;
      log1[c] = obs1();
      log2[c] = obs2();
      sb_sample();
      if (mac_en) n_mac++;
      if (mac_clr) n_clr++;
      if (res_valid) n_valid++;
      if (res_last) n_last++;
      if (done) begin n_done++; done_cyc = c; end
      if (mac_en2 !== mac_clr2) clr_mis2++;
    end
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].which == 1) check($sformatf("vec1_c%0d", vecs[v].cyc), 32'(log1[vecs[v].cyc]), 32'(vecs[v].exp));
      else                    check($sformatf("vec2_c%0d", vecs[v].cyc), 32'(log2[vecs[v].cyc]), 32'(vecs[v].exp));
    end
    check("run1_mac_count", 32'(n_mac), 32'd36);
    check("run1_clr_count", 32'(n_clr), 32'd9);
    check("run1_valid_count", 32'(n_valid), 32'd9);
    check("run1_last_count", 32'(n_last), 32'd1);
    check("run1_done_count", 32'(n_done), 32'd1);
    check("run1_done_cycle", 32'(done_cyc), 32'd55);
    check("run1_sb_left", 32'(exp_q.size()), 32'd0);
    check("dut2_clr_eq_en", 32'(clr_mis2), 32'd0);

    // Run 2: output stall of several cycles plus start re-pulsed in ACCUM and in DONE
    exp_q.delete();
    push_all();
    res_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 0;
    while (!res_valid && budget < 12) begin tick(); budget++; end
    check("stall_valid_seen", 32'(res_valid), 32'd1);
    hold_row = res_row; hold_col = res_col;
    check("stall_first_idx", {30'd0, res_row, res_col} >> 0, 32'd0);
    stall_ok = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      if (!(res_valid && res_row == hold_row && res_col == hold_col && !rd_en && !mac_en)) stall_ok = 1'b0;
    end
    check("stall_hold", 32'(stall_ok), 32'd1);
    res_ready = 1'b1;
    sb_sample();
    tick();
    check("stall_resume", {24'd0, rd_en, res_valid, 2'd0, a_addr}, {24'd0, 1'b1, 1'b0, 2'd0, 4'd0});
    check("stall_resume_b", 32'(b_addr), 32'd1);
    n_done = 0;
    budget = 0;
    while (n_done == 0 && budget < 100) begin
      sb_sample();
      tick();
      budget++;
      start = 1'b0;
      if (done) begin n_done++; start = 1'b1; end
    end
    check("run2_done_seen", 32'(n_done), 32'd1);
    for (int c = 0; c < 20; c++) begin
      tick();
      start = 1'b0;
      if (done) n_done++;
    end
    check("run2_one_done", 32'(n_done), 32'd1);
    check("run2_idle_after", 32'(busy), 32'd0);
    check("run2_sb_left", 32'(exp_q.size()), 32'd0);

    // Run 3: reset in the third ACCUM cycle of element (0,1), then a clean restart
    exp_q.delete();
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      sb_sample();
      tick();
    end
    check("rst_pre_state", {16'd0, 7'd0, rd_en, a_addr, b_addr}, {16'd0, 7'd0, 1'b1, 4'd2, 4'd7});
    reset = 1'b1;
    tick();
    check("rst_outputs_zero", 32'(obs1()), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    n_done = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done) n_done++;
    end
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_stays_idle", 32'(busy), 32'd0);
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_first", 32'(obs1()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)));
    budget = 0;
    while (!done && budget < 80) begin
      sb_sample();
      tick();
      budget++;
    end
    check("restart_done", 32'(done), 32'd1);
    check("restart_sb_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
